// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, immediate formats, ALU encodings, ID/EX bundle.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_SB, IMM_UJ, IMM_U} imm_sel_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Write-back source select carried to EX/MEM/WB.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        fun3;
        logic [3:0]        alu_control;
        logic              op_a_sel;    // 0: rs1, 1: pc
        logic              op_b_sel;    // 0: rs2, 1: imm
        logic              load;
        logic              store;
        logic              branch;
        logic              jalr;
        logic              reg_write;
        logic [1:0]        mem_to_reg;
        logic              illegal;
    } id_ex_t;

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_sel_e sel);
        logic [XLEN-1:0] imm;
        case (sel)
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_SB:  imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_UJ:  imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'h000};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA; caller decides when instr[30] is meaningful.
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read/1-write integer register file, x0 hard-wired to zero, optional WB bypass.
// Latency: reads combinational; writes land on the clock edge.
// Backpressure: none; writes are never stalled.
module id_regfile
    import rv32i_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int RegAddress = 5,
    parameter int BypassEn   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddress-1:0] rs1,
    input  logic [RegAddress-1:0] rs2,
    output logic [DataWidth-1:0]  rs1_data,
    output logic [DataWidth-1:0]  rs2_data,
    input  logic                  wb_en,
    input  logic [RegAddress-1:0] wb_rd,
    input  logic [DataWidth-1:0]  wb_data
);

    localparam int NumRegs = 2 ** RegAddress;

    logic [DataWidth-1:0] regs [NumRegs];

    // Storage: synchronous clear, write-back of any register except x0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Port 1 read: x0 forced to zero, same-cycle WB value wins when bypass is built.
    always_comb begin
        rs1_data = regs[rs1];
        if (rs1 == '0)
            rs1_data = '0;
        else if (BypassEn != 0 && wb_en && wb_rd == rs1)
            rs1_data = wb_data;
    end

    // Port 2 read: same rules as port 1.
    always_comb begin
        rs2_data = regs[rs2];
        if (rs2 == '0)
            rs2_data = '0;
        else if (BypassEn != 0 && wb_en && wb_rd == rs2)
            rs2_data = wb_data;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, operand read with WB bypass, load-use bubble, ID/EX register.
// Latency: one cycle from if_valid&if_ready to ex_valid; one instruction per cycle unstalled.
// Backpressure: holds the bundle and drops if_ready while ex_ready=0 or on a load-use hazard.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int RegAddress = 5,
    parameter int BypassEn   = 1,
    parameter int CntWidth   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [DataWidth-1:0]  if_instr,
    input  logic [DataWidth-1:0]  if_pc,
    input  logic                  wb_en,
    input  logic [RegAddress-1:0] wb_rd,
    input  logic [DataWidth-1:0]  wb_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output id_ex_t                ex_bundle,
    output logic [CntWidth-1:0]   bubble_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} pipe_state_e;

    pipe_state_e           state, state_nxt;
    logic [RegAddress-1:0] rs1, rs2;
    logic [DataWidth-1:0]  rs1_data, rs2_data;
    logic                  uses_rs1, uses_rs2, has_imm, hazard, adv, load_en, bubble_inc;
    imm_sel_e              imm_sel;
    id_ex_t                bundle_nxt;

    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];

    id_regfile #(
        .DataWidth  (DataWidth),
        .RegAddress (RegAddress),
        .BypassEn   (BypassEn)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    // Decode: control fields, operand usage and immediate format from the opcode.
    always_comb begin
        bundle_nxt          = '0;
        bundle_nxt.pc       = if_pc;
        bundle_nxt.rs1_data = rs1_data;
        bundle_nxt.rs2_data = rs2_data;
        bundle_nxt.rs1      = rs1;
        bundle_nxt.rs2      = rs2;
        bundle_nxt.rd       = if_instr[11:7];
        bundle_nxt.fun3     = if_instr[14:12];
        bundle_nxt.op_b_sel = 1'b1;
        imm_sel             = IMM_I;
        has_imm             = 1'b1;
        uses_rs1            = 1'b0;
        uses_rs2            = 1'b0;
        case (if_instr[6:0])
            OP_LUI: begin
                imm_sel                = IMM_U;
                bundle_nxt.alu_control = ALU_PASSB;
                bundle_nxt.reg_write   = 1'b1;
            end
            OP_AUIPC: begin
                imm_sel              = IMM_U;
                bundle_nxt.op_a_sel  = 1'b1;
                bundle_nxt.reg_write = 1'b1;
            end
            OP_JAL: begin
                imm_sel               = IMM_UJ;
                bundle_nxt.op_a_sel   = 1'b1;
                bundle_nxt.reg_write  = 1'b1;
                bundle_nxt.mem_to_reg = WB_PC4;
            end
            OP_JALR: begin
                uses_rs1              = 1'b1;
                bundle_nxt.jalr       = 1'b1;
                bundle_nxt.reg_write  = 1'b1;
                bundle_nxt.mem_to_reg = WB_PC4;
            end
            OP_BRANCH: begin
                imm_sel                = IMM_SB;
                uses_rs1               = 1'b1;
                uses_rs2               = 1'b1;
                bundle_nxt.branch      = 1'b1;
                bundle_nxt.op_b_sel    = 1'b0;
                bundle_nxt.alu_control = ALU_SUB;
            end
            OP_LOAD: begin
                uses_rs1              = 1'b1;
                bundle_nxt.load       = 1'b1;
                bundle_nxt.reg_write  = 1'b1;
                bundle_nxt.mem_to_reg = WB_MEM;
            end
            OP_STORE: begin
                imm_sel          = IMM_S;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                bundle_nxt.store = 1'b1;
            end
            OP_IMM: begin
                uses_rs1               = 1'b1;
                bundle_nxt.reg_write   = 1'b1;
                bundle_nxt.alu_control = alu_fn(if_instr[14:12],
                                                (if_instr[14:12] == 3'b101) && if_instr[30]);
            end
            OP_REG: begin
                has_imm                = 1'b0;
                uses_rs1               = 1'b1;
                uses_rs2               = 1'b1;
                bundle_nxt.op_b_sel    = 1'b0;
                bundle_nxt.reg_write   = 1'b1;
                bundle_nxt.alu_control = alu_fn(if_instr[14:12], if_instr[30]);
            end
            default: begin
                // Unknown opcode: no side effects, EX raises the exception from illegal.
                has_imm             = 1'b0;
                bundle_nxt.op_b_sel = 1'b0;
                bundle_nxt.illegal  = 1'b1;
            end
        endcase
        bundle_nxt.imm = has_imm ? gen_imm(if_instr, imm_sel) : '0;
    end

    assign ex_valid = (state == FULL);
    assign adv      = !ex_valid || ex_ready;
    assign hazard   = if_valid && ex_valid && ex_bundle.load && (ex_bundle.rd != '0) &&
                      ((uses_rs1 && rs1 == ex_bundle.rd) || (uses_rs2 && rs2 == ex_bundle.rd));

    // Pipeline control: flush beats hazard beats back-pressure; if_ready low in reset.
    always_comb begin
        state_nxt  = state;
        if_ready   = 1'b0;
        load_en    = 1'b0;
        bubble_inc = 1'b0;
        if (rst) begin
            if (flush) begin
                if_ready  = 1'b1;
                state_nxt = EMPTY;
            end else if (hazard) begin
                if (adv) begin
                    state_nxt  = EMPTY;
                    bubble_inc = 1'b1;
                end
            end else if (adv) begin
                if_ready  = 1'b1;
                load_en   = if_valid;
                state_nxt = if_valid ? FULL : EMPTY;
            end
        end
    end

    // State, ID/EX bundle and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            ex_bundle  <= '0;
            bubble_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_en) ex_bundle <= bundle_nxt;
            if (bubble_inc && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
    import rv32i_pkg::*;

    localparam int CW = 3;   // narrow counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [31:0]   if_instr = '0;
    logic [31:0]   if_pc = '0;
    logic          wb_en = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [31:0]   wb_data = '0;
    logic          flush = 1'b0;
    logic          ex_valid;
    logic          ex_ready = 1'b1;
    id_ex_t        ex_bundle;
    logic [CW-1:0] bubble_cnt;

    id_stage #(.DataWidth(32), .RegAddress(5), .BypassEn(1), .CntWidth(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_bundle(ex_bundle), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_uses(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
            7'b1100111, 7'b0000011, 7'b0010011: return 2'b01;
            default:                            return 2'b00;
        endcase
    endfunction

    function automatic id_ex_t ref_bundle(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
        id_ex_t b;
        logic [31:0] sx;
        logic [3:0] alu_tab [8];
        logic [2:0] f3;
        alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = ins[14:12];
        sx = {32{ins[31]}};
        b = '0;
        b.pc = pc; b.rs1_data = r1; b.rs2_data = r2;
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7]; b.fun3 = f3;
        case (ins[6:0])
            7'b0110111: begin b.imm = {ins[31:12], 12'h0}; b.alu_control = 4'd10; b.op_b_sel = 1; b.reg_write = 1; end
            7'b0010111: begin b.imm = {ins[31:12], 12'h0}; b.op_a_sel = 1; b.op_b_sel = 1; b.reg_write = 1; end
            7'b1101111: begin
                b.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                b.op_a_sel = 1; b.op_b_sel = 1; b.reg_write = 1; b.mem_to_reg = 2;
            end
            7'b1100111: begin b.imm = (sx << 12) | 32'(ins[31:20]); b.jalr = 1; b.op_b_sel = 1; b.reg_write = 1; b.mem_to_reg = 2; end
            7'b1100011: begin
                b.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                b.branch = 1; b.alu_control = 4'd1;
            end
            7'b0000011: begin b.imm = (sx << 12) | 32'(ins[31:20]); b.load = 1; b.op_b_sel = 1; b.reg_write = 1; b.mem_to_reg = 1; end
            7'b0100011: begin b.imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]); b.store = 1; b.op_b_sel = 1; end
            7'b0010011: begin
                b.imm = (sx << 12) | 32'(ins[31:20]); b.op_b_sel = 1; b.reg_write = 1;
                b.alu_control = alu_tab[f3] + ((f3 == 3'd5 && ins[30]) ? 4'd1 : 4'd0);
            end
            7'b0110011: begin
                b.reg_write = 1;
                b.alu_control = alu_tab[f3] + (((f3 == 3'd0 || f3 == 3'd5) && ins[30]) ? 4'd1 : 4'd0);
            end
            default: b.illegal = 1;
        endcase
        return b;
    endfunction

    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0;
    id_ex_t      m_b = '0;
    int          m_cnt = 0;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic logic m_hazard();
        logic [1:0] u;
        u = ref_uses(if_instr);
        return if_valid && m_valid && m_b.load && m_b.rd != 0 &&
               ((u[0] && if_instr[19:15] == m_b.rd) || (u[1] && if_instr[24:20] == m_b.rd));
    endfunction

    function automatic logic m_if_ready();
        if (!rst) return 1'b0;
        if (flush) return 1'b1;
        return !m_hazard() && (!m_valid || ex_ready);
    endfunction

    // Model advance on each edge, from the inputs held over that edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 0; m_b = '0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else begin
            if (flush) m_valid = 0;
            else if (m_hazard()) begin
                if (!m_valid || ex_ready) begin
                    m_valid = 0;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
            end else if (!m_valid || ex_ready) begin
                if (if_valid) begin
                    m_b = ref_bundle(if_instr, if_pc, m_read(if_instr[19:15]), m_read(if_instr[24:20]));
                    m_valid = 1;
                end else m_valid = 0;
            end
            if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ex_valid", 192'(ex_valid), 192'(m_valid));
            chk("if_ready", 192'(if_ready), 192'(m_if_ready()));
            chk("bubble_cnt", 192'(bubble_cnt), 192'(m_cnt));
            if (m_valid) chk("ex_bundle", 192'(ex_bundle), 192'(m_b));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
        return {imm, rs, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs);
        return {12'h000, rs, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1; if_instr = ins; if_pc = pc;
    endtask

    logic [31:0] fmt_ins [4];
    logic [31:0] fmt_imm [4];

    initial begin
        fmt_ins[0] = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011};          // sw x2,-4(x1)
        fmt_imm[0] = 32'hFFFF_FFFC;
        fmt_ins[1] = {1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011}; // beq x1,x2,+8
        fmt_imm[1] = 32'h0000_0008;
        fmt_ins[2] = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};             // jal x1,+2048
        fmt_imm[2] = 32'h0000_0800;
        fmt_ins[3] = {20'h12345, 5'd5, 7'b0110111};                           // lui x5,0x12345
        fmt_imm[3] = 32'h1234_5000;

        // Reset
        step(); cmp_en = 1'b1; step();
        chk("rst ex_valid", 192'(ex_valid), 192'(0));
        chk("rst bubble_cnt", 192'(bubble_cnt), 192'(0));
        chk("rst bundle", 192'(ex_bundle), 192'(0));
        chk("rst if_ready", 192'(if_ready), 192'(0));
        rst = 1'b1;

        // Every register reads zero after reset
        for (int i = 0; i < 16; i++) begin
            offer(e_add(5'd0, 5'(2 * i + 1), 5'((2 * i + 2) % 32)), 32'(i * 4));
            step();
            chk("rst regs", 192'({ex_bundle.rs1_data, ex_bundle.rs2_data}), 192'(0));
        end

        // Streaming with same-cycle WB bypass
        offer(e_addi(5'd1, 5'd0, 12'd5), 32'h100);
        step();
        chk("addi imm", 192'(ex_bundle.imm), 192'(5));
        offer(e_add(5'd2, 5'd1, 5'd1), 32'h104);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        step();
        wb_en = 1'b0;
        chk("stream valid", 192'(ex_valid), 192'(1));
        chk("stream rs data", 192'({ex_bundle.rs1_data, ex_bundle.rs2_data}), 192'({32'd5, 32'd5}));
        chk("stream imm", 192'(ex_bundle.imm), 192'(0));
        chk("stream pc", 192'(ex_bundle.pc), 192'(32'h104));

        // Load-use: one bubble
        offer(e_lw(5'd3, 5'd1), 32'h108);
        step();
        offer(e_add(5'd4, 5'd3, 5'd2), 32'h10C);
        #1 chk("lu if_ready", 192'(if_ready), 192'(0));
        step();
        chk("lu bubble valid", 192'(ex_valid), 192'(0));
        chk("lu bubble_cnt", 192'(bubble_cnt), 192'(1));
        step();
        chk("lu issue", 192'({ex_valid, ex_bundle.rd}), 192'({1'b1, 5'd4}));

        // Load-use with WB to rs in the releasing cycle
        offer(e_lw(5'd6, 5'd1), 32'h110);
        step();
        offer(e_add(5'd7, 5'd6, 5'd6), 32'h114);
        step();
        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h77;
        step();
        wb_en = 1'b0;
        chk("lu wb bypass", 192'({ex_bundle.rd, ex_bundle.rs1_data}), 192'({5'd7, 32'h77}));

        // Back-pressure
        offer(e_addi(5'd8, 5'd0, 12'd1), 32'h118);
        step();
        ex_ready = 1'b0;
        offer(e_addi(5'd9, 5'd0, 12'd2), 32'h11C);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp if_ready", 192'(if_ready), 192'(0));
            step();
            chk("bp hold", 192'({ex_valid, ex_bundle.rd, ex_bundle.imm}), 192'({1'b1, 5'd8, 32'd1}));
        end
        ex_ready = 1'b1;
        step();
        chk("bp release", 192'({ex_bundle.rd, ex_bundle.imm}), 192'({5'd9, 32'd2}));

        // Hazard under back-pressure, then flush over hazard
        offer(e_lw(5'd10, 5'd1), 32'h120);
        step();
        ex_ready = 1'b0;
        offer(e_add(5'd11, 5'd10, 5'd10), 32'h124);
        step();
        chk("hz hold", 192'({ex_valid, ex_bundle.rd, bubble_cnt}), 192'({1'b1, 5'd10, 3'd2}));
        flush = 1'b1;
        #1 chk("flush if_ready", 192'(if_ready), 192'(1));
        step();
        flush = 1'b0; ex_ready = 1'b1;
        chk("flush result", 192'({ex_valid, bubble_cnt}), 192'({1'b0, 3'd2}));
        if_valid = 1'b0;
        step();

        // Counter saturation: 7 more bubbles from 2 must stop at 7
        for (int k = 0; k < 7; k++) begin
            offer(e_lw(5'd3, 5'd1), 32'h200);
            step();
            offer(e_add(5'd4, 5'd3, 5'd3), 32'h204);
            step();
            step();
        end
        chk("sat bubble_cnt", 192'(bubble_cnt), 192'(7));

        // Illegal opcode, WB to x0
        offer(32'h0000_0080, 32'h300);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        step();
        chk("illegal flags", 192'({ex_bundle.illegal, ex_bundle.reg_write, ex_bundle.load}), 192'(3'b100));
        offer(e_add(5'd12, 5'd0, 5'd0), 32'h304);
        step();
        wb_en = 1'b0;
        chk("x0 bypass", 192'(ex_bundle.rs1_data), 192'(0));
        offer(e_add(5'd13, 5'd0, 5'd0), 32'h308);
        step();
        chk("x0 read", 192'(ex_bundle.rs1_data), 192'(0));

        // Immediate formats
        for (int i = 0; i < 4; i++) begin
            offer(fmt_ins[i], 32'h400 + 32'(i * 4));
            step();
            chk("imm fmt", 192'(ex_bundle.imm), 192'(fmt_imm[i]));
        end

        // Reset in the middle of a stall
        offer(e_lw(5'd13, 5'd1), 32'h500);
        step();
        ex_ready = 1'b0;
        offer(e_add(5'd14, 5'd13, 5'd13), 32'h504);
        step();
        rst = 1'b0;
        #1 chk("mid rst if_ready", 192'(if_ready), 192'(0));
        step();
        chk("mid rst state", 192'({ex_valid, bubble_cnt}), 192'(0));
        rst = 1'b1;
        #1 chk("post rst if_ready", 192'(if_ready), 192'(1));
        if_valid = 1'b0; ex_ready = 1'b1;
        step();
        step();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined RV32I instruction-decode stage, the parametrised successor to the combinational decode block. It accepts fetched instructions over a valid/ready handshake and reads operands from an internal register file with write-back bypass. It detects load-use hazards and inserts bubbles, honours EX-stage flushes, and delivers a registered ID/EX bundle to the execute stage.

## Interface
- `DataWidth`, 32: datapath width.
- `RegAddress`, 5: register index width; register count is 2**RegAddress.
- `BypassEn`, 1: 1 = WB-to-ID same-cycle bypass on operand read; 0 = no bypass.
- `CntWidth`, 16: width of the bubble performance counter.

Ports:
- `clk`  in  1: clock; one clock domain.
- `rst`  in  1: reset, synchronous, active-low.
- `if_valid`  in  1: fetch offers an instruction.
- `if_ready`  out  1: decode accepts the instruction this cycle.
- `if_instr`  in  DataWidth: instruction word.
- `if_pc`  in  DataWidth: instruction address.
- `wb_en`  in  1: write-back enable.
- `wb_rd`  in  RegAddress: write-back destination register.
- `wb_data`  in  DataWidth: write-back data.
- `flush`  in  1: EX redirect; kill ID and ID/EX contents.
- `ex_valid`  out  1: ID/EX bundle valid.
- `ex_ready`  in  1: execute stage consumes the bundle.
- `ex_bundle`  out  id_ex_t: contents are pc, rs1_data, rs2_data, imm, rs1, rs2, rd, fun3, alu_control[3:0], op_a_sel, op_b_sel, load, store, branch, jalr, reg_write, mem_to_reg[1:0] and illegal.
- `bubble_cnt`  out  CntWidth: count of bubbles inserted for hazards.

## Operation
- **Decode.** Decode is combinational from `if_instr`.
  - Immediate selection covers the I, S, SB, UJ and U formats.
  - `uses_rs1` and `uses_rs2` are derived per opcode.
  - An unknown opcode sets `illegal`=1 and forces reg_write, load, store, branch and jalr to 0.
- **Register file.** Reads are combinational; the write happens on the clock edge when `wb_en` is 1 and `wb_rd` is not 0.
  - x0 always reads 0.
  - If `BypassEn` is 1 and `wb_en` is 1 and `wb_rd` equals rs and rs is not 0, the read returns `wb_data`.
- **Hazard.** `hazard` = `if_valid` & `ex_valid` & `ex_bundle.load` & `ex_bundle.rd`≠0 & ((`uses_rs1` & rs1==rd) | (`uses_rs2` & rs2==rd)).
- **Pipeline register** (two-state FSM, EMPTY/FULL, encoded by `ex_valid`). `adv` = !`ex_valid` | `ex_ready`. Cases are listed in priority order:
  1. `flush`=1: `if_ready`=1 and the offered instruction is discarded; next `ex_valid`=0.
  2. `hazard` & `adv`: `if_ready`=0; next `ex_valid`=0 (bubble); `bubble_cnt` += 1.
  3. `hazard` & !`adv`: hold; `if_ready`=0.
  4. !`hazard` & `adv`: `if_ready`=1; when `if_valid`=1, load the bundle and set next `ex_valid`=1, otherwise next `ex_valid`=0.
  5. !`adv`: hold the bundle unchanged; `if_ready`=0.
- **Flush priority.** `flush` overrides `hazard` and back-pressure.
- **Bubble counter.** `bubble_cnt` saturates at all-ones and never wraps.
- EX/MEM forwarding is outside this block. Exactly one bubble per load-use is required.

## Timing
- **Reset.** While `rst`=0 at the clock edge, all of the following are 0:
  - `ex_valid`, every `ex_bundle` field, `bubble_cnt`, and all registers.
  - `if_ready` is also 0 during reset.
- **Latency.** One cycle from `if_valid`&`if_ready` to `ex_valid`.
  - Throughput is one instruction per cycle with no hazard and `ex_ready`=1.
- **Bundle stability.** `ex_bundle` stays stable while `ex_valid`=1 and `ex_ready`=0.
- **WB timing.** A write lands at the edge. A read in the same cycle sees the new value only via bypass; the following cycle always sees it.
- **WB during stall.** WB writes occur regardless of stall or flush.
- **WB/ID overlap.** WB to rs in the same cycle that a hazard stall releases: the bundle captures the bypassed value.
- **Reset mid-stall.** Reset during a stall clears the state; the first cycle after reset behaves as EMPTY.

## Structure
- **Package `rv32i_pkg`** contains:
  - opcode constants;
  - the `imm_sel_e` enum (I, S, SB, UJ, U);
  - ALU control encodings;
  - the `id_ex_t` packed struct, parametrised by DataWidth and RegAddress through package localparams.
- **Sub-module `id_regfile`:** 2-read/1-write register file with the `BypassEn` option.
- **Remaining logic:** decode, immediate generation, hazard detection and the pipeline register live in `id_stage`.

## Test plan
- **Reset:** drive `rst`=0 for 2 cycles -> `ex_valid`=0, `bubble_cnt`=0, and x1–x31 read 0.
- **Streaming:** `addi x1,x0,5` then `add x2,x1,x1` with WB of x1=5 applied in the second instruction's ID cycle, `BypassEn`=1 -> second bundle has rs1_data=rs2_data=5 and imm=0; bundles arrive on consecutive cycles.
- **Load-use:** `lw x3,0(x1)` in EX, `add x4,x3,x2` offered, `ex_ready`=1 -> one cycle with `ex_valid`=0 and `if_ready`=0, then the add issues; `bubble_cnt`=1.
- **Back-pressure:** hold `ex_ready`=0 for 3 cycles with the bundle valid -> `if_ready`=0 and the bundle is unchanged; release -> the next instruction loads the following cycle.
- **Flush over hazard:** assert `flush` in the same cycle as a hazard -> `if_ready`=1, next `ex_valid`=0, `bubble_cnt` unchanged.
- **Illegal opcode and x0:** opcode 7'b0000000 -> `illegal`=1, reg_write=0; WB with `wb_rd`=0, `wb_data`=32'hDEADBEEF -> x0 still reads 0.
